// File: rtl/multicycle_control_unit_pkg.sv
// Shared encodings for the multicycle MIPS control unit: state enum, opcode/funct
// values, ULA operation codes and datapath mux selects.
package mcu_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
      ADDIEX   = 4'd9,
      ADDIWB   = 4'd10,
      JUMP     = 4'd11,
      TRAP     = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ULA_AND = 3'b000;
   localparam logic [2:0] ULA_OR  = 3'b001;
   localparam logic [2:0] ULA_ADD = 3'b010;
   localparam logic [2:0] ULA_NOR = 3'b011;
   localparam logic [2:0] ULA_SUB = 3'b110;
   localparam logic [2:0] ULA_SLT = 3'b111;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ULA    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_control_unit_alu_decoder.sv
// R-type function field decode: ULA operation plus a flag for supported functs,
// used by the FSM to divert unknown R-type instructions to the trap state.
module alu_decoder
   import mcu_pkg::*;
(
   input  logic [5:0] funct,
   output logic [2:0] ula_control,
   output logic       funct_legal
);

   always_comb begin
      ula_control = ULA_ADD;
      funct_legal = 1'b1;
      case (funct)
         FN_ADD:  ula_control = ULA_ADD;
         FN_SUB:  ula_control = ULA_SUB;
         FN_AND:  ula_control = ULA_AND;
         FN_OR:   ula_control = ULA_OR;
         FN_NOR:  ula_control = ULA_NOR;
         FN_SLT:  ula_control = ULA_SLT;
         default: funct_legal = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback with
// memory wait states, optional single-step gating and an illegal-instruction trap.
module multicycle_control_unit
   import mcu_pkg::*;
#(
   parameter int MEM_WAIT  = 0,
   parameter int STEP_MODE = 0,
   parameter int ULA_W     = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   input  logic [5:0]       OP,
   input  logic [5:0]       Funct,
   output logic             PCWrite,
   output logic             Branch,
   output logic             BranchNe,
   output logic             IorD,
   output logic             IRWrite,
   output logic             MemWrite,
   output logic             RegWrite,
   output logic             RegDst,
   output logic             MemtoReg,
   output logic             ULASrcA,
   output logic [1:0]       ULASrcB,
   output logic [1:0]       PCSrc,
   output logic [ULA_W-1:0] ULAControl,
   output logic             instr_done,
   output logic             illegal,
   output logic [3:0]       state_o
);

   localparam int CW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

   state_t          state, state_next;
   logic [CW-1:0]   cnt;
   logic            is_load, is_bne;
   logic            advance, mem_state, last_wait;
   logic [2:0]      r_ula;
   logic            funct_legal;

   alu_decoder u_alu_decoder (
      .funct       (Funct),
      .ula_control (r_ula),
      .funct_legal (funct_legal)
   );

   assign advance   = (STEP_MODE == 0) || step;
   assign mem_state = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
   assign last_wait = (cnt == CW'(MEM_WAIT));
   assign state_o   = state;

   // Instruction kind is latched in DECODE so later states ignore OP changes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= FETCH;
         cnt     <= '0;
         is_load <= 1'b0;
         is_bne  <= 1'b0;
      end else if (advance) begin
         state <= state_next;
         if (state_next != state)
            cnt <= '0;
         else if (mem_state && !last_wait)
            cnt <= cnt + 1'b1;
         if (state == DECODE) begin
            is_load <= (OP == OP_LW);
            is_bne  <= (OP == OP_BNE);
         end
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         FETCH:    if (last_wait) state_next = DECODE;
         DECODE: begin
            case (OP)
               OP_LW, OP_SW:   state_next = MEMADR;
               OP_RTYPE:       state_next = funct_legal ? EXECUTE : TRAP;
               OP_BEQ, OP_BNE: state_next = BRANCH;
               OP_ADDI:        state_next = ADDIEX;
               OP_J:           state_next = JUMP;
               default:        state_next = TRAP;
            endcase
         end
         MEMADR:   state_next = is_load ? MEMREAD : MEMWRITE;
         MEMREAD:  if (last_wait) state_next = MEMWB;
         MEMWB:    state_next = FETCH;
         MEMWRITE: if (last_wait) state_next = FETCH;
         EXECUTE:  state_next = ALUWB;
         ALUWB:    state_next = FETCH;
         BRANCH:   state_next = FETCH;
         ADDIEX:   state_next = ADDIWB;
         ADDIWB:   state_next = FETCH;
         JUMP:     state_next = FETCH;
         TRAP:     state_next = TRAP;
         default:  state_next = FETCH;
      endcase
   end

   always_comb begin
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      BranchNe   = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemWrite   = 1'b0;
      RegWrite   = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      ULASrcA    = 1'b0;
      ULASrcB    = SRCB_B;
      PCSrc      = PCSRC_ULA;
      ULAControl = '0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            ULASrcB    = SRCB_FOUR;
            ULAControl = ULA_W'(ULA_ADD);
            IRWrite    = last_wait;
            PCWrite    = last_wait;
         end
         DECODE: begin
            ULASrcB    = SRCB_IMM_SH;
            ULAControl = ULA_W'(ULA_ADD);
         end
         MEMADR, ADDIEX: begin
            ULASrcA    = 1'b1;
            ULASrcB    = SRCB_IMM;
            ULAControl = ULA_W'(ULA_ADD);
         end
         MEMREAD:  IorD = 1'b1;
         MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWRITE: begin
            IorD       = 1'b1;
            MemWrite   = last_wait;
            instr_done = last_wait;
         end
         EXECUTE: begin
            ULASrcA    = 1'b1;
            ULAControl = ULA_W'(r_ula);
         end
         ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            ULASrcA    = 1'b1;
            ULAControl = ULA_W'(ULA_SUB);
            PCSrc      = PCSRC_ALUOUT;
            Branch     = !is_bne;
            BranchNe   = is_bne;
            instr_done = 1'b1;
         end
         ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         JUMP: begin
            PCSrc      = PCSRC_JUMP;
            PCWrite    = 1'b1;
            instr_done = 1'b1;
         end
         TRAP:     illegal = 1'b1;
         default:  ;
      endcase
      // A held step cycle must not commit anything to the datapath.
      if (!advance) begin
         PCWrite    = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         Branch     = 1'b0;
         BranchNe   = 1'b0;
         instr_done = 1'b0;
      end
      if (rst) begin
         PCWrite    = 1'b0;
         Branch     = 1'b0;
         BranchNe   = 1'b0;
         IorD       = 1'b0;
         IRWrite    = 1'b0;
         MemWrite   = 1'b0;
         RegWrite   = 1'b0;
         RegDst     = 1'b0;
         MemtoReg   = 1'b0;
         ULASrcA    = 1'b0;
         ULASrcB    = SRCB_B;
         PCSrc      = PCSRC_ULA;
         ULAControl = '0;
         instr_done = 1'b0;
         illegal    = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for the multicycle control unit: three instances cover the plain,
// memory-wait and single-step configurations; a negedge monitor checks every cycle.
module tb_multicycle_control_unit;
   import mcu_pkg::*;

   typedef struct packed {
      logic       pcw, br, brne, iord, irw, mw, rw, rd, m2r, sa;
      logic [1:0] sb, pcs;
      logic [2:0] ula;
      logic       done, ill;
      logic [3:0] st;
   } ov_t;

   typedef struct packed {
      logic [1:0] sel;
      ov_t        ov;
   } exp_t;

   logic       clk = 1'b0;
   logic [2:0] rst = 3'b111;
   logic       step = 1'b0;
   logic [5:0] OP = 6'h00;
   logic [5:0] Funct = 6'h20;

   logic [2:0] pcw, br, brne, iord, irw, mw, rw, rd, m2r, sa, done, ill;
   logic [1:0] sb [3];
   logic [1:0] pcs [3];
   logic [2:0] ula [3];
   logic [3:0] st [3];
   ov_t        act_v [3];

   exp_t  exp_q[$];
   string nm_q[$];
   int    checks = 0;
   int    fails = 0;
   logic [5:0] cur_op = 6'h00;
   logic [5:0] cur_fn = 6'h20;

   always #5 clk = ~clk;

   multicycle_control_unit #(.MEM_WAIT(0), .STEP_MODE(0)) u_dut0 (
      .clk(clk), .rst(rst[0]), .step(step), .OP(OP), .Funct(Funct),
      .PCWrite(pcw[0]), .Branch(br[0]), .BranchNe(brne[0]), .IorD(iord[0]),
      .IRWrite(irw[0]), .MemWrite(mw[0]), .RegWrite(rw[0]), .RegDst(rd[0]),
      .MemtoReg(m2r[0]), .ULASrcA(sa[0]), .ULASrcB(sb[0]), .PCSrc(pcs[0]),
      .ULAControl(ula[0]), .instr_done(done[0]), .illegal(ill[0]), .state_o(st[0])
   );

   multicycle_control_unit #(.MEM_WAIT(2), .STEP_MODE(0)) u_dut1 (
      .clk(clk), .rst(rst[1]), .step(step), .OP(OP), .Funct(Funct),
      .PCWrite(pcw[1]), .Branch(br[1]), .BranchNe(brne[1]), .IorD(iord[1]),
      .IRWrite(irw[1]), .MemWrite(mw[1]), .RegWrite(rw[1]), .RegDst(rd[1]),
      .MemtoReg(m2r[1]), .ULASrcA(sa[1]), .ULASrcB(sb[1]), .PCSrc(pcs[1]),
      .ULAControl(ula[1]), .instr_done(done[1]), .illegal(ill[1]), .state_o(st[1])
   );

   multicycle_control_unit #(.MEM_WAIT(0), .STEP_MODE(1)) u_dut2 (
      .clk(clk), .rst(rst[2]), .step(step), .OP(OP), .Funct(Funct),
      .PCWrite(pcw[2]), .Branch(br[2]), .BranchNe(brne[2]), .IorD(iord[2]),
      .IRWrite(irw[2]), .MemWrite(mw[2]), .RegWrite(rw[2]), .RegDst(rd[2]),
      .MemtoReg(m2r[2]), .ULASrcA(sa[2]), .ULASrcB(sb[2]), .PCSrc(pcs[2]),
      .ULAControl(ula[2]), .instr_done(done[2]), .illegal(ill[2]), .state_o(st[2])
   );

   for (genvar g = 0; g < 3; g++) begin : g_act
      assign act_v[g] = {pcw[g], br[g], brne[g], iord[g], irw[g], mw[g], rw[g], rd[g],
                         m2r[g], sa[g], sb[g], pcs[g], ula[g], done[g], ill[g], st[g]};
   end

   // Expected per-state outputs, written out by hand from the state table.
   function automatic ov_t base(input logic [3:0] s);
      ov_t o = '0;
      o.st = s;
      return o;
   endfunction

   function automatic ov_t f_fetch(input logic last);
      ov_t o = base(4'd0);
      o.sb = 2'b01; o.ula = 3'b010; o.irw = last; o.pcw = last;
      return o;
   endfunction

   function automatic ov_t f_decode();
      ov_t o = base(4'd1);
      o.sb = 2'b11; o.ula = 3'b010;
      return o;
   endfunction

   function automatic ov_t f_memadr();
      ov_t o = base(4'd2);
      o.sa = 1'b1; o.sb = 2'b10; o.ula = 3'b010;
      return o;
   endfunction

   function automatic ov_t f_memread();
      ov_t o = base(4'd3);
      o.iord = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_memwb();
      ov_t o = base(4'd4);
      o.m2r = 1'b1; o.rw = 1'b1; o.done = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_memwrite(input logic last);
      ov_t o = base(4'd5);
      o.iord = 1'b1; o.mw = last; o.done = last;
      return o;
   endfunction

   function automatic ov_t f_execute(input logic [2:0] u);
      ov_t o = base(4'd6);
      o.sa = 1'b1; o.ula = u;
      return o;
   endfunction

   function automatic ov_t f_aluwb();
      ov_t o = base(4'd7);
      o.rd = 1'b1; o.rw = 1'b1; o.done = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_branch(input logic ne);
      ov_t o = base(4'd8);
      o.sa = 1'b1; o.ula = 3'b110; o.pcs = 2'b01; o.br = !ne; o.brne = ne; o.done = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_addiex();
      ov_t o = base(4'd9);
      o.sa = 1'b1; o.sb = 2'b10; o.ula = 3'b010;
      return o;
   endfunction

   function automatic ov_t f_addiwb();
      ov_t o = base(4'd10);
      o.rw = 1'b1; o.done = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_jump();
      ov_t o = base(4'd11);
      o.pcs = 2'b10; o.pcw = 1'b1; o.done = 1'b1;
      return o;
   endfunction

   function automatic ov_t f_trap();
      ov_t o = base(4'd12);
      o.ill = 1'b1;
      return o;
   endfunction

   function automatic ov_t gate(input ov_t i);
      ov_t o = i;
      o.pcw = 1'b0; o.irw = 1'b0; o.mw = 1'b0; o.rw = 1'b0;
      o.br = 1'b0; o.brne = 1'b0; o.done = 1'b0;
      return o;
   endfunction

   task automatic set_instr(input logic [5:0] op, input logic [5:0] fn);
      cur_op = op;
      cur_fn = fn;
   endtask

   // One clock of stimulus: only the selected instance leaves reset.
   task automatic cyc(input int sel, input logic r, input logic s, input ov_t e, input string nm);
      exp_t x;
      @(posedge clk);
      #1;
      rst       = 3'b111;
      rst[sel]  = r;
      step      = s;
      OP        = cur_op;
      Funct     = cur_fn;
      x.sel     = 2'(sel);
      x.ov      = e;
      exp_q.push_back(x);
      nm_q.push_back(nm);
   endtask

   // Valid/ready here is trivial: the DUT presents a Moore output vector every cycle,
   // and each queued entry describes exactly one cycle, consumed at the following negedge.
   always @(negedge clk) begin
      exp_t  e;
      string nm;
      ov_t   a;
      if (exp_q.size() > 0) begin
         e  = exp_q.pop_front();
         nm = nm_q.pop_front();
         a  = act_v[e.sel];
         checks++;
         if (a !== e.ov) begin
            fails++;
            $display("FAIL %s (dut%0d): got %h expected %h", nm, e.sel, a, e.ov);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);

      // Plain configuration.
      set_instr(OP_RTYPE, FN_ADD);
      cyc(0, 1, 0, base(4'd0), "rst0_a");
      cyc(0, 1, 0, base(4'd0), "rst0_b");
      cyc(0, 0, 0, f_fetch(1), "add_fetch");
      cyc(0, 0, 0, f_decode(), "add_decode");
      cyc(0, 0, 0, f_execute(3'b010), "add_exec");
      cyc(0, 0, 0, f_aluwb(), "add_aluwb");
      set_instr(OP_RTYPE, FN_SUB);
      cyc(0, 0, 0, f_fetch(1), "sub_fetch");
      cyc(0, 0, 0, f_decode(), "sub_decode");
      cyc(0, 0, 0, f_execute(3'b110), "sub_exec");
      cyc(0, 0, 0, f_aluwb(), "sub_aluwb");
      set_instr(OP_RTYPE, FN_SLT);
      cyc(0, 0, 0, f_fetch(1), "slt_fetch");
      cyc(0, 0, 0, f_decode(), "slt_decode");
      cyc(0, 0, 0, f_execute(3'b111), "slt_exec");
      cyc(0, 0, 0, f_aluwb(), "slt_aluwb");
      set_instr(OP_BNE, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "bne_fetch");
      cyc(0, 0, 0, f_decode(), "bne_decode");
      cyc(0, 0, 0, f_branch(1), "bne_branch");
      set_instr(OP_BEQ, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "beq_fetch");
      cyc(0, 0, 0, f_decode(), "beq_decode");
      cyc(0, 0, 0, f_branch(0), "beq_branch");
      set_instr(OP_SW, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "sw_fetch");
      cyc(0, 0, 0, f_decode(), "sw_decode");
      cyc(0, 0, 0, f_memadr(), "sw_memadr");
      cyc(0, 0, 0, f_memwrite(1), "sw_memwrite");
      set_instr(OP_LW, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "lw_fetch");
      cyc(0, 0, 0, f_decode(), "lw_decode");
      set_instr(OP_SW, 6'h00);
      cyc(0, 0, 0, f_memadr(), "lw_memadr_opchg");
      cyc(0, 0, 0, f_memread(), "lw_memread");
      cyc(0, 0, 0, f_memwb(), "lw_memwb");
      set_instr(OP_ADDI, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "addi_fetch");
      cyc(0, 0, 0, f_decode(), "addi_decode");
      cyc(0, 0, 0, f_addiex(), "addi_ex");
      cyc(0, 0, 0, f_addiwb(), "addi_wb");
      set_instr(OP_J, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "j_fetch");
      cyc(0, 0, 0, f_decode(), "j_decode");
      cyc(0, 0, 0, f_jump(), "j_jump");
      set_instr(6'h3F, 6'h00);
      cyc(0, 0, 0, f_fetch(1), "ill_op_fetch");
      cyc(0, 0, 0, f_decode(), "ill_op_decode");
      set_instr(OP_RTYPE, FN_ADD);
      for (int i = 0; i < 20; i++) cyc(0, 0, 0, f_trap(), "ill_op_trap");
      cyc(0, 1, 0, base(4'd12), "ill_op_rst");
      set_instr(OP_RTYPE, 6'h21);
      cyc(0, 0, 0, f_fetch(1), "ill_fn_fetch");
      cyc(0, 0, 0, f_decode(), "ill_fn_decode");
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, f_trap(), "ill_fn_trap");
      cyc(0, 1, 0, base(4'd12), "ill_fn_rst");

      // Two memory wait states.
      set_instr(OP_LW, 6'h00);
      cyc(1, 1, 0, base(4'd0), "rst1_a");
      cyc(1, 1, 0, base(4'd0), "rst1_b");
      cyc(1, 0, 0, f_fetch(0), "w_lw_fetch0");
      cyc(1, 0, 0, f_fetch(0), "w_lw_fetch1");
      cyc(1, 0, 0, f_fetch(1), "w_lw_fetch2");
      cyc(1, 0, 0, f_decode(), "w_lw_decode");
      cyc(1, 0, 0, f_memadr(), "w_lw_memadr");
      for (int i = 0; i < 3; i++) cyc(1, 0, 0, f_memread(), "w_lw_memread");
      set_instr(OP_SW, 6'h00);
      cyc(1, 0, 0, f_memwb(), "w_lw_memwb");
      cyc(1, 0, 0, f_fetch(0), "w_sw_fetch0");
      cyc(1, 0, 0, f_fetch(0), "w_sw_fetch1");
      cyc(1, 0, 0, f_fetch(1), "w_sw_fetch2");
      cyc(1, 0, 0, f_decode(), "w_sw_decode");
      cyc(1, 0, 0, f_memadr(), "w_sw_memadr");
      cyc(1, 0, 0, f_memwrite(0), "w_sw_memwrite0");
      cyc(1, 0, 0, f_memwrite(0), "w_sw_memwrite1");
      cyc(1, 0, 0, f_memwrite(1), "w_sw_memwrite2");
      cyc(1, 0, 0, f_fetch(0), "w_next_fetch0");

      // Single-step configuration.
      set_instr(OP_LW, 6'h00);
      cyc(2, 1, 0, base(4'd0), "rst2_a");
      cyc(2, 1, 0, base(4'd0), "rst2_b");
      cyc(2, 0, 0, gate(f_fetch(1)), "st_hold_fetch_a");
      cyc(2, 0, 0, gate(f_fetch(1)), "st_hold_fetch_b");
      cyc(2, 0, 1, f_fetch(1), "st_step_fetch");
      cyc(2, 0, 0, gate(f_decode()), "st_hold_decode");
      cyc(2, 0, 1, f_decode(), "st_step_decode");
      cyc(2, 0, 1, f_memadr(), "st_step_memadr");
      cyc(2, 0, 0, gate(f_memread()), "st_hold_memread");
      cyc(2, 1, 0, base(4'd3), "st_rst_memread");
      cyc(2, 0, 0, gate(f_fetch(1)), "st_after_rst");
      cyc(2, 0, 1, f_fetch(1), "st_after_rst_step");

      @(posedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
